sys_wr_arbiter: RTL and testbench

- Shares the single 8-bit system register write bus between two requesters.
- Requester 0 is the SPI debug write stream: strobe-only, no backpressure, buffered in a small FIFO.
- Requester 1 is a host port with a valid/ready handshake.
- Grants are round-robin with bounded bursts. Writes are issued on a registered output port that the target can stall.

---
 rtl/sys_wr_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_sys_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_wr_arbiter.sv
// Purpose: shares one registered system-register write port between a buffered
//          debug strobe stream and a valid/ready host port, round-robin with bounded bursts.
// Latency: host valid -> wr_o 1 cycle; debug strobe -> wr_o 2 cycles (no fall-through).
// Backpressure: wr_busy_i holds the issued write; no grant, pop or host_ready_o while held.
//
// Ports:
//   sys_clk, sys_rst_n                    clock, async active-low reset
//   dbg_wr_i, dbg_waddr_i, dbg_wdata_i    debug write strobe stream (no backpressure)
//   dbg_ovf_o, dbg_ovf_clr_i              sticky drop flag and its clear
//   dbg_level_o                           debug FIFO occupancy 0..FIFO_DEPTH
//   host_valid_i, host_ready_o            host handshake
//   host_addr_i, host_data_i              host write payload
//   wr_o, waddr_o, wdata_o, wr_busy_i     registered write port and target stall
//   owner_o                               0 IDLE, 1 DBG, 2 HOST

// Purpose: small FIFO with registered occupancy; caller qualifies push/pop.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: none internally; caller must not push when full without a pop.
module sys_wr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
endmodule

module sys_wr_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST      = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        dbg_wr_i,
  input  logic [AW-1:0]               dbg_waddr_i,
  input  logic [DW-1:0]               dbg_wdata_i,
  output logic                        dbg_ovf_o,
  input  logic                        dbg_ovf_clr_i,
  output logic [$clog2(FIFO_DEPTH):0] dbg_level_o,
  input  logic                        host_valid_i,
  output logic                        host_ready_o,
  input  logic [AW-1:0]               host_addr_i,
  input  logic [DW-1:0]               host_data_i,
  output logic                        wr_o,
  output logic [AW-1:0]               waddr_o,
  output logic [DW-1:0]               wdata_o,
  input  logic                        wr_busy_i,
  output logic [1:0]                  owner_o
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DBG  = 2'd1,
    ST_HOST = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic              last_host, last_host_n;
  logic              grant_dbg, grant_host;
  logic              slot_free, req_dbg, req_host;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [AW+DW-1:0]  fifo_head;

  sys_wr_fifo #(
    .W     (AW + DW),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_dbg_fifo (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .push     (fifo_push),
    .push_dat ({dbg_waddr_i, dbg_wdata_i}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (dbg_level_o)
  );

  assign slot_free = !wr_o || !wr_busy_i;
  assign req_dbg   = !fifo_empty;
  assign req_host  = host_valid_i;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign fifo_pop  = grant_dbg;
  assign fifo_push = dbg_wr_i && (!fifo_full || fifo_pop);
  assign drop      = dbg_wr_i && fifo_full && !fifo_pop;

  assign host_ready_o = grant_host;
  assign owner_o      = state;
  assign cnt_inc      = (cnt == BURST_C) ? cnt : cnt + CW'(1);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_host_n = last_host;
    grant_dbg   = 1'b0;
    grant_host  = 1'b0;
    if (slot_free) begin
      case (state)
        ST_IDLE: begin
          // Tie goes to whoever was not served last.
          if (req_dbg && (!req_host || last_host)) grant_dbg = 1'b1;
          else if (req_host)                       grant_host = 1'b1;
        end
        ST_DBG: begin
          if (req_dbg && (cnt < BURST_C || !req_host)) grant_dbg = 1'b1;
          else if (req_host)                           grant_host = 1'b1;
        end
        ST_HOST: begin
          if (req_host && (cnt < BURST_C || !req_dbg)) grant_host = 1'b1;
          else if (req_dbg)                            grant_dbg = 1'b1;
        end
        default: ;
      endcase

      if (grant_dbg) begin
        state_n = ST_DBG;
        cnt_n   = (state == ST_DBG) ? cnt_inc : CW'(1);
      end else if (grant_host) begin
        state_n = ST_HOST;
        cnt_n   = (state == ST_HOST) ? cnt_inc : CW'(1);
      end else begin
        state_n = ST_IDLE;
        cnt_n   = '0;
        if (state == ST_DBG)       last_host_n = 1'b0;
        else if (state == ST_HOST) last_host_n = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_host <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_host <= last_host_n;
    end
  end

  // Output register only advances when the slot is free; otherwise it holds.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else if (slot_free) begin
      wr_o <= grant_dbg || grant_host;
      if (grant_dbg) begin
        {waddr_o, wdata_o} <= fifo_head;
      end else if (grant_host) begin
        waddr_o <= host_addr_i;
        wdata_o <= host_data_i;
      end
    end
  end

  // A drop coinciding with a clear keeps the flag set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dbg_ovf_o <= 1'b0;
    end else if (drop) begin
      dbg_ovf_o <= 1'b1;
    end else if (dbg_ovf_clr_i) begin
      dbg_ovf_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sys_wr_arbiter.sv
// Purpose: self-checking bench for sys_wr_arbiter against a queue-based reference model.
// Latency: model predicts every output for every cycle, sampled on the falling edge.
// Backpressure: wr_busy_i driven both in directed scenarios and randomly.
module tb_sys_wr_arbiter;
  localparam int DEPTH = 4;
  localparam int BURST = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       dbg_wr;
  logic [7:0] dbg_waddr;
  logic [7:0] dbg_wdata;
  logic       dbg_ovf;
  logic       dbg_ovf_clr;
  logic [2:0] dbg_level;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] host_addr;
  logic [7:0] host_data;
  logic       wr;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       wr_busy;
  logic [1:0] owner;

  sys_wr_arbiter #(
    .AW(8), .DW(8), .FIFO_DEPTH(DEPTH), .BURST(BURST)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .dbg_wr_i      (dbg_wr),
    .dbg_waddr_i   (dbg_waddr),
    .dbg_wdata_i   (dbg_wdata),
    .dbg_ovf_o     (dbg_ovf),
    .dbg_ovf_clr_i (dbg_ovf_clr),
    .dbg_level_o   (dbg_level),
    .host_valid_i  (host_valid),
    .host_ready_o  (host_ready),
    .host_addr_i   (host_addr),
    .host_data_i   (host_data),
    .wr_o          (wr),
    .waddr_o       (waddr),
    .wdata_o       (wdata),
    .wr_busy_i     (wr_busy),
    .owner_o       (owner)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner 0 idle / 1 debug / 2 host, debug FIFO as a queue.
  int          m_owner;
  int          m_cnt;
  int          m_last;
  bit          m_wr;
  bit          m_ovf;
  logic [7:0]  m_addr;
  logic [7:0]  m_data;
  logic [15:0] m_q[$];
  bit          ready_seen;

  task automatic model_reset();
    m_owner = 0;
    m_cnt   = 0;
    m_last  = 2;
    m_wr    = 0;
    m_ovf   = 0;
    m_addr  = '0;
    m_data  = '0;
    m_q.delete();
  endtask

  task automatic model_cycle();
    int          g;
    bit          free, dq, own, oth;
    logic [15:0] head;
    bit          drop;
    g    = 0;
    head = '0;
    if (!sys_rst_n) model_reset();
    free = !m_wr || !wr_busy;
    dq   = (m_q.size() != 0);
    if (sys_rst_n && free) begin
      if (m_owner == 0) begin
        if (dq && host_valid) g = (m_last == 2) ? 1 : 2;
        else if (dq)          g = 1;
        else if (host_valid)  g = 2;
      end else begin
        own = (m_owner == 1) ? dq : host_valid;
        oth = (m_owner == 1) ? host_valid : dq;
        if (own && (m_cnt < BURST || !oth)) g = m_owner;
        else if (oth)                       g = 3 - m_owner;
      end
    end
    ready_seen = host_ready;
    chk("wr_o",    32'(wr),         32'(m_wr));
    chk("waddr_o", 32'(waddr),      32'(m_addr));
    chk("wdata_o", 32'(wdata),      32'(m_data));
    chk("ready",   32'(host_ready), 32'(g == 2));
    chk("level",   32'(dbg_level),  m_q.size());
    chk("owner",   32'(owner),      m_owner);
    chk("ovf",     32'(dbg_ovf),    32'(m_ovf));
    if (!sys_rst_n) return;

    if (g == 1) head = m_q.pop_front();
    drop = 0;
    if (dbg_wr) begin
      if (m_q.size() < DEPTH) m_q.push_back({dbg_waddr, dbg_wdata});
      else                    drop = 1;
    end
    if (drop)             m_ovf = 1;
    else if (dbg_ovf_clr) m_ovf = 0;
    if (free) begin
      if (g != 0) begin
        m_wr = 1;
        if (g == 1) {m_addr, m_data} = head;
        else begin
          m_addr = host_addr;
          m_data = host_data;
        end
        m_cnt   = (g == m_owner) ? ((m_cnt < BURST) ? m_cnt + 1 : BURST) : 1;
        m_owner = g;
      end else begin
        m_wr = 0;
        if (m_owner != 0) m_last = m_owner;
        m_owner = 0;
        m_cnt   = 0;
      end
    end
  endtask

  // One cycle: check/advance model on the falling edge, return just after the rising edge.
  task automatic step();
    @(negedge sys_clk);
    model_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    dbg_wr      = 1'b0;
    dbg_ovf_clr = 1'b0;
    host_valid  = 1'b0;
    wr_busy     = 1'b0;
  endtask

  initial begin
    int k;
    int n;
    sys_rst_n = 1'b0;
    dbg_waddr = '0;
    dbg_wdata = '0;
    host_addr = '0;
    host_data = '0;
    idle_inputs();
    model_reset();

    // Reset state.
    #3;
    chk("rst0_wr",    32'(wr),         0);
    chk("rst0_waddr", 32'(waddr),      0);
    chk("rst0_wdata", 32'(wdata),      0);
    chk("rst0_ready", 32'(host_ready), 0);
    chk("rst0_ovf",   32'(dbg_ovf),    0);
    chk("rst0_level", 32'(dbg_level),  0);
    chk("rst0_owner", 32'(owner),      0);
    step();
    step();
    sys_rst_n = 1'b1;
    step();

    // Single debug write.
    dbg_wr    = 1'b1;
    dbg_waddr = 8'h12;
    dbg_wdata = 8'h34;
    step();
    dbg_wr = 1'b0;
    repeat (5) step();

    // Host stream, advancing on each accepted beat.
    k = 0;
    n = 0;
    host_valid = 1'b1;
    while (k < 8 && n < 40) begin
      host_addr = 8'(8'h40 + k);
      host_data = 8'(8'hA0 + k);
      step();
      if (ready_seen) k++;
      n++;
    end
    host_valid = 1'b0;
    chk("host_beats", k, 8);
    repeat (3) step();

    // Both requesting: runs of BURST alternate.
    dbg_wr    = 1'b1;
    dbg_waddr = 8'($urandom);
    dbg_wdata = 8'($urandom);
    step();
    host_valid = 1'b1;
    repeat (24) begin
      dbg_waddr = 8'($urandom);
      dbg_wdata = 8'($urandom);
      host_addr = 8'($urandom);
      host_data = 8'($urandom);
      step();
    end
    idle_inputs();
    repeat (14) step();
    dbg_ovf_clr = 1'b1;
    step();
    dbg_ovf_clr = 1'b0;
    step();

    // Overflow while the port is stalled on a host write.
    host_valid = 1'b1;
    host_addr  = 8'h55;
    host_data  = 8'h66;
    wr_busy    = 1'b1;
    step();
    host_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dbg_wr    = 1'b1;
      dbg_waddr = 8'(8'h80 + i);
      dbg_wdata = 8'(8'hC0 + i);
      step();
    end
    dbg_wr = 1'b0;
    step();
    chk("ovf_level", 32'(dbg_level), 4);
    chk("ovf_flag",  32'(dbg_ovf),   1);
    wr_busy = 1'b0;
    repeat (8) step();
    dbg_ovf_clr = 1'b1;
    step();
    dbg_ovf_clr = 1'b0;
    step();
    chk("ovf_clr", 32'(dbg_ovf), 0);

    // Stall during host writes.
    host_valid = 1'b1;
    host_addr  = 8'h21;
    host_data  = 8'h43;
    step();
    host_addr  = 8'h22;
    host_data  = 8'h44;
    wr_busy    = 1'b1;
    repeat (3) step();
    wr_busy = 1'b0;
    step();
    host_valid = 1'b0;
    repeat (3) step();

    // Asynchronous reset mid-burst with entries buffered.
    host_valid = 1'b1;
    host_addr  = 8'h77;
    wr_busy    = 1'b1;
    step();
    host_valid = 1'b0;
    repeat (3) begin
      dbg_wr    = 1'b1;
      dbg_waddr = 8'($urandom);
      dbg_wdata = 8'($urandom);
      step();
    end
    dbg_wr = 1'b0;
    chk("pre_rst_wr",    32'(wr),        32'(m_wr));
    chk("pre_rst_level", 32'(dbg_level), m_q.size());
    #1 sys_rst_n = 1'b0;
    #1;
    chk("async_rst_wr",    32'(wr),        0);
    chk("async_rst_level", 32'(dbg_level), 0);
    chk("async_rst_owner", 32'(owner),     0);
    idle_inputs();
    step();
    step();
    sys_rst_n = 1'b1;
    repeat (4) step();

    // Randomized traffic.
    repeat (600) begin
      dbg_wr      = ($urandom_range(2) == 0);
      dbg_waddr   = 8'($urandom);
      dbg_wdata   = 8'($urandom);
      host_valid  = ($urandom_range(1) == 0);
      host_addr   = 8'($urandom);
      host_data   = 8'($urandom);
      wr_busy     = ($urandom_range(3) == 0);
      dbg_ovf_clr = ($urandom_range(15) == 0);
      step();
    end
    idle_inputs();
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
